// File: rtl/hough_line_select_pkg.sv
// Shared types and defaults for the Hough line-selection stage.
// Holds the global geometry (rho/theta bins, vote width), the FSM state type
// and the candidate record passed between the scanner and the top-N sorter.
package hough_line_select_pkg;

  localparam int RHOS             = 256;
  localparam int RHO_RANGE        = 2 * RHOS;
  localparam int THETAS           = 180;
  localparam int ACCUM_BUFF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hls_state_t;

  typedef struct packed {
    logic signed [15:0]            rho;
    logic [7:0]                    theta;
    logic [ACCUM_BUFF_WIDTH-1:0]   votes;
    logic                          valid;
  } line_cand_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hough_line_select_sorter.sv
// Purpose : registered top-N insertion sorter, slots kept descending by votes.
// Latency : an accepted candidate is visible in the slots one cycle later.
// Backpr. : none; accepts a candidate every cycle, the lowest slot drops out.
// Ports   : clock/reset, i_clear (empties all slots), i_in_valid/i_in_cand
//           (qualified candidate), o_slots (slot 0 = most votes), o_count.
module hough_topn_sorter
  import hough_line_select_pkg::*;
#(
  parameter int NUM_CANDIDATES = 4,
  localparam int CW = $clog2(NUM_CANDIDATES + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_clear,
  input  logic                             i_in_valid,
  input  line_cand_t                       i_in_cand,
  output line_cand_t [NUM_CANDIDATES-1:0]  o_slots,
  output logic [CW-1:0]                    o_count
);

  line_cand_t [NUM_CANDIDATES-1:0] r_slots;
  line_cand_t [NUM_CANDIDATES-1:0] w_next;
  logic [NUM_CANDIDATES-1:0]       w_beats;
  logic [CW-1:0]                   r_count;

  // A slot is beaten when empty or strictly lower; equal votes keep the
  // earlier-scanned cell ahead. Slots are sorted with empties last, so
  // w_beats is monotone and the first set bit is the insertion point.
  always_comb begin
    w_beats = '0;
    w_next  = r_slots;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      w_beats[i] = !r_slots[i].valid || (i_in_cand.votes > r_slots[i].votes);
    end
    if (i_in_valid) begin
      if (w_beats[0]) begin
        w_next[0] = i_in_cand;
      end
      for (int i = 1; i < NUM_CANDIDATES; i++) begin
        if (w_beats[i]) begin
          w_next[i] = w_beats[i-1] ? r_slots[i-1] : i_in_cand;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slots <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_slots <= '0;
      r_count <= '0;
    end else begin
      r_slots <= w_next;
      // While not full the last slot is empty, so every valid input inserts.
      if (i_in_valid && (r_count != CW'(NUM_CANDIDATES))) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_slots = r_slots;
  assign o_count = r_count;

endmodule

// File: rtl/hough_line_select.sv
// Purpose : scans the Hough accumulator after accumulation and keeps the
//           NUM_CANDIDATES strongest cells at/above a latched threshold.
// Latency : N = RHO_RANGE*THETAS reads back to back; done pulses at cycle N+2.
// Backpr. : none; one read per cycle, start ignored while busy.
// Ports   : clock/reset, start/threshold, accum_rd_en/addr/data (1-cycle BRAM),
//           busy/done, cand_rho/theta/votes/valid (slot 0 in LSBs), count.
module hough_line_select #(
  parameter int RHO_RANGE      = hough_line_select_pkg::RHO_RANGE,
  parameter int THETAS         = hough_line_select_pkg::THETAS,
  parameter int ACCUM_WIDTH    = hough_line_select_pkg::ACCUM_BUFF_WIDTH,
  parameter int NUM_CANDIDATES = 4,
  parameter int ADDR_WIDTH     = $clog2(RHO_RANGE * THETAS),
  localparam int CW = $clog2(NUM_CANDIDATES + 1)
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [ACCUM_WIDTH-1:0]                  threshold,
  output logic                                    accum_rd_en,
  output logic [ADDR_WIDTH-1:0]                   accum_rd_addr,
  input  logic [ACCUM_WIDTH-1:0]                  accum_rd_data,
  output logic                                    busy,
  output logic                                    done,
  output logic [NUM_CANDIDATES*16-1:0]            cand_rho,
  output logic [NUM_CANDIDATES*8-1:0]             cand_theta,
  output logic [NUM_CANDIDATES*ACCUM_WIDTH-1:0]   cand_votes,
  output logic [NUM_CANDIDATES-1:0]               cand_valid,
  output logic [CW-1:0]                           count
);
  import hough_line_select_pkg::*;

  localparam int RW     = hough_line_select_pkg::clog2_min1(RHO_RANGE);
  localparam int TW     = hough_line_select_pkg::clog2_min1(THETAS);
  localparam int NCELLS = RHO_RANGE * THETAS;

  hls_state_t r_state, w_next_state;
  logic       w_accept, w_scan, w_last;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [RW-1:0]          r_rho;
  logic [TW-1:0]          r_theta;
  logic [ACCUM_WIDTH-1:0] r_thresh;

  // Tag of the read in flight; it lines up with accum_rd_data.
  logic                   r_tag_vld;
  logic [RW-1:0]          r_tag_rho;
  logic [TW-1:0]          r_tag_theta;

  line_cand_t                       w_in_cand;
  logic                             w_qualify;
  line_cand_t [NUM_CANDIDATES-1:0]  w_slots;
  logic [CW-1:0]                    w_count;

  assign w_scan = (r_state == ST_SCAN);
  assign w_last = w_scan && (r_addr == ADDR_WIDTH'(NCELLS - 1));

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_SCAN;
          w_accept     = 1'b1;
        end
      end
      ST_SCAN: begin
        if (w_last) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE: begin
        if (start) begin
          w_next_state = ST_SCAN;
          w_accept     = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // The flat address runs alongside rho/theta so no multiplier is needed;
  // it stops on the last cell rather than wrapping past the buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_rho    <= '0;
      r_theta  <= '0;
      r_thresh <= '0;
    end else if (w_accept) begin
      r_addr   <= '0;
      r_rho    <= '0;
      r_theta  <= '0;
      r_thresh <= threshold;
    end else if (w_scan && !w_last) begin
      r_addr <= r_addr + 1'b1;
      if (r_theta == TW'(THETAS - 1)) begin
        r_theta <= '0;
        r_rho   <= r_rho + 1'b1;
      end else begin
        r_theta <= r_theta + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag_vld   <= 1'b0;
      r_tag_rho   <= '0;
      r_tag_theta <= '0;
    end else begin
      r_tag_vld   <= w_scan;
      r_tag_rho   <= r_rho;
      r_tag_theta <= r_theta;
    end
  end

  always_comb begin
    w_in_cand       = '0;
    w_in_cand.rho   = 16'(r_tag_rho) - 16'(RHO_RANGE / 2);
    w_in_cand.theta = 8'(r_tag_theta);
    w_in_cand.votes = ACCUM_BUFF_WIDTH'(accum_rd_data);
    w_in_cand.valid = 1'b1;
  end

  assign w_qualify = r_tag_vld && (accum_rd_data >= r_thresh);

  hough_topn_sorter #(
    .NUM_CANDIDATES (NUM_CANDIDATES)
  ) u_sorter (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_accept),
    .i_in_valid (w_qualify),
    .i_in_cand  (w_in_cand),
    .o_slots    (w_slots),
    .o_count    (w_count)
  );

  assign accum_rd_en   = w_scan;
  assign accum_rd_addr = r_addr;
  assign busy          = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign done          = (r_state == ST_DONE);
  assign count         = w_count;

  always_comb begin
    cand_rho   = '0;
    cand_theta = '0;
    cand_votes = '0;
    cand_valid = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      cand_rho[i*16 +: 16]                   = w_slots[i].rho;
      cand_theta[i*8 +: 8]                   = w_slots[i].theta;
      cand_votes[i*ACCUM_WIDTH +: ACCUM_WIDTH] = ACCUM_WIDTH'(w_slots[i].votes);
      cand_valid[i]                          = w_slots[i].valid;
    end
  end

endmodule

// File: tb/tb_hough_line_select.sv
// Directed bench for hough_line_select on a 4x4 accumulator keeping 2 lines.
// A behavioural 1-cycle BRAM feeds the scanner; cycle c is the period after
// edge c-1, where edge 0 samples start. Outputs are sampled on the negedge.
module tb_hough_line_select;

  localparam int RR = 4;
  localparam int TH = 4;
  localparam int NC = 2;
  localparam int N  = RR * TH;
  localparam int AW = 4;
  localparam int VW = 16;
  localparam int CW = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [VW-1:0]      threshold = '0;
  logic               accum_rd_en;
  logic [AW-1:0]      accum_rd_addr;
  logic [VW-1:0]      accum_rd_data = '0;
  logic               busy;
  logic               done;
  logic [NC*16-1:0]   cand_rho;
  logic [NC*8-1:0]    cand_theta;
  logic [NC*VW-1:0]   cand_votes;
  logic [NC-1:0]      cand_valid;
  logic [CW-1:0]      count;

  logic [VW-1:0] mem [0:N-1];

  int n_cmp = 0;
  int n_bad = 0;

  logic          rec_en    [1:N+2];
  logic [AW-1:0] rec_addr  [1:N+2];
  logic          rec_busy  [1:N+2];
  logic          rec_done  [1:N+2];
  logic [CW-1:0] rec_cnt   [1:N+2];
  logic [NC-1:0] rec_valid [1:N+2];

  hough_line_select #(
    .RHO_RANGE      (RR),
    .THETAS         (TH),
    .ACCUM_WIDTH    (VW),
    .NUM_CANDIDATES (NC),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .threshold     (threshold),
    .accum_rd_en   (accum_rd_en),
    .accum_rd_addr (accum_rd_addr),
    .accum_rd_data (accum_rd_data),
    .busy          (busy),
    .done          (done),
    .cand_rho      (cand_rho),
    .cand_theta    (cand_theta),
    .cand_votes    (cand_votes),
    .cand_valid    (cand_valid),
    .count         (count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (accum_rd_en) accum_rd_data <= mem[accum_rd_addr];
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  // Start pulse sampled at the next rising edge (edge 0).
  task automatic launch_now(input logic [VW-1:0] thr);
    start = 1'b1;
    threshold = thr;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic launch(input logic [VW-1:0] thr);
    @(negedge clock);
    launch_now(thr);
  endtask

  // Records cycles 1..N+2. Threshold is scribbled in cycle 3 (must have no
  // effect) and an extra start may be pulsed in a chosen cycle.
  task automatic run_cycles(input int extra_start);
    for (int c = 1; c <= N + 2; c++) begin
      @(negedge clock);
      rec_en[c]    = accum_rd_en;
      rec_addr[c]  = accum_rd_addr;
      rec_busy[c]  = busy;
      rec_done[c]  = done;
      rec_cnt[c]   = count;
      rec_valid[c] = cand_valid;
      if (c == 3) threshold = '0;
      start = (c == extra_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (accum_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", accum_rd_en); end
    n_cmp++; if (accum_rd_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", accum_rd_addr); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_cmp++; if (cand_rho !== '0 || cand_theta !== '0 || cand_votes !== '0) begin n_bad++; $display("FAIL reset_cand: got %h/%h/%h want 0", cand_rho, cand_theta, cand_votes); end
    n_cmp++; if (cand_valid !== '0 || count !== '0) begin n_bad++; $display("FAIL reset_valid_count: got %b/%0d want 0/0", cand_valid, count); end
    reset = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clock);
        if (accum_rd_en !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL idle_no_read: got activity=%b want 0", seen); end
    end
  endtask

  task automatic test_all_zero();
    clear_mem();
    launch(16'd1);
    run_cycles(-1);
    for (int c = 1; c <= N + 2; c++) begin
      n_cmp++; if (rec_en[c] !== (c <= N)) begin n_bad++; $display("FAIL zero_rd_en c%0d: got %b want %b", c, rec_en[c], (c <= N)); end
      if (c <= N) begin
        n_cmp++; if (rec_addr[c] !== AW'(c - 1)) begin n_bad++; $display("FAIL zero_addr c%0d: got %0d want %0d", c, rec_addr[c], c - 1); end
      end
      n_cmp++; if (rec_busy[c] !== (c <= N + 1)) begin n_bad++; $display("FAIL zero_busy c%0d: got %b want %b", c, rec_busy[c], (c <= N + 1)); end
      n_cmp++; if (rec_done[c] !== (c == N + 2)) begin n_bad++; $display("FAIL zero_done c%0d: got %b want %b", c, rec_done[c], (c == N + 2)); end
    end
    n_cmp++; if (count !== 2'd0 || cand_valid !== 2'b00) begin n_bad++; $display("FAIL zero_result: got count=%0d valid=%b want 0/00", count, cand_valid); end
    @(negedge clock);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_sorting();
    clear_mem();
    mem[5] = 16'd10; mem[9] = 16'd20; mem[14] = 16'd15;
    launch(16'd5);
    run_cycles(-1);
    n_cmp++; if (rec_done[N+2] !== 1'b1) begin n_bad++; $display("FAIL sort_done: got %b want 1", rec_done[N+2]); end
    n_cmp++; if (count !== 2'd2 || cand_valid !== 2'b11) begin n_bad++; $display("FAIL sort_count: got %0d/%b want 2/11", count, cand_valid); end
    n_cmp++; if (cand_rho[15:0] !== 16'sd0 || cand_theta[7:0] !== 8'd1 || cand_votes[15:0] !== 16'd20) begin n_bad++; $display("FAIL sort_slot0: got rho=%0d th=%0d v=%0d want 0/1/20", $signed(cand_rho[15:0]), cand_theta[7:0], cand_votes[15:0]); end
    n_cmp++; if (cand_rho[31:16] !== 16'sd1 || cand_theta[15:8] !== 8'd2 || cand_votes[31:16] !== 16'd15) begin n_bad++; $display("FAIL sort_slot1: got rho=%0d th=%0d v=%0d want 1/2/15", $signed(cand_rho[31:16]), cand_theta[15:8], cand_votes[31:16]); end
    repeat (3) @(negedge clock);
    n_cmp++; if (cand_votes !== {16'd15, 16'd20} || count !== 2'd2 || done !== 1'b0) begin n_bad++; $display("FAIL sort_hold: got v=%h cnt=%0d done=%b want 000f0014/2/0", cand_votes, count, done); end
  endtask

  task automatic test_tie();
    clear_mem();
    mem[3] = 16'd12; mem[7] = 16'd12; mem[10] = 16'd11;
    launch(16'd12);
    run_cycles(-1);
    n_cmp++; if (rec_cnt[1] !== 2'd0 || rec_valid[1] !== 2'b00) begin n_bad++; $display("FAIL tie_clear: got %0d/%b want 0/00", rec_cnt[1], rec_valid[1]); end
    n_cmp++; if (count !== 2'd2 || cand_valid !== 2'b11) begin n_bad++; $display("FAIL tie_count: got %0d/%b want 2/11", count, cand_valid); end
    n_cmp++; if (cand_rho[15:0] !== 16'hFFFE || cand_theta[7:0] !== 8'd3 || cand_votes[15:0] !== 16'd12) begin n_bad++; $display("FAIL tie_slot0: got rho=%h th=%0d v=%0d want fffe/3/12", cand_rho[15:0], cand_theta[7:0], cand_votes[15:0]); end
    n_cmp++; if (cand_rho[31:16] !== 16'hFFFF || cand_theta[15:8] !== 8'd3 || cand_votes[31:16] !== 16'd12) begin n_bad++; $display("FAIL tie_slot1: got rho=%h th=%0d v=%0d want ffff/3/12", cand_rho[31:16], cand_theta[15:8], cand_votes[31:16]); end
  endtask

  task automatic test_start_while_busy();
    clear_mem();
    mem[3] = 16'd12; mem[7] = 16'd12; mem[10] = 16'd11;
    launch(16'd12);
    run_cycles(5);
    for (int c = 1; c <= N + 2; c++) begin
      if (c <= N) begin
        n_cmp++; if (rec_en[c] !== 1'b1 || rec_addr[c] !== AW'(c - 1)) begin n_bad++; $display("FAIL busy_addr c%0d: got en=%b a=%0d want 1/%0d", c, rec_en[c], rec_addr[c], c - 1); end
      end
      n_cmp++; if (rec_done[c] !== (c == N + 2)) begin n_bad++; $display("FAIL busy_done c%0d: got %b want %b", c, rec_done[c], (c == N + 2)); end
    end
    n_cmp++; if (count !== 2'd2 || cand_votes !== {16'd12, 16'd12}) begin n_bad++; $display("FAIL busy_result: got %0d/%h want 2/000c000c", count, cand_votes); end
  endtask

  task automatic test_midscan_reset();
    logic seen_en, seen_done;
    clear_mem();
    mem[5] = 16'd10; mem[9] = 16'd20; mem[14] = 16'd15;
    launch(16'd5);
    repeat (8) @(negedge clock);
    n_cmp++; if (count !== 2'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got cnt=%0d busy=%b want 1/1", count, busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || accum_rd_en !== 1'b0 || accum_rd_addr !== '0) begin n_bad++; $display("FAIL rst_async_ctl: got busy=%b en=%b a=%0d want 0/0/0", busy, accum_rd_en, accum_rd_addr); end
    n_cmp++; if (count !== 2'd0 || cand_valid !== 2'b00 || cand_votes !== '0 || cand_rho !== '0) begin n_bad++; $display("FAIL rst_async_cand: got cnt=%0d valid=%b v=%h want 0", count, cand_valid, cand_votes); end
    @(negedge clock);
    reset = 1'b0;
    seen_en = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clock);
      if (accum_rd_en !== 1'b0) seen_en = 1'b1;
      if (done !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++; if (seen_en !== 1'b0) begin n_bad++; $display("FAIL rst_no_read: got %b want 0", seen_en); end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rst_no_done: got %b want 0", seen_done); end
  endtask

  task automatic test_back_to_back();
    clear_mem();
    mem[5] = 16'd10; mem[9] = 16'd20; mem[14] = 16'd15;
    launch(16'd5);
    run_cycles(-1);
    n_cmp++; if (done !== 1'b1 || count !== 2'd2) begin n_bad++; $display("FAIL b2b_first: got done=%b cnt=%0d want 1/2", done, count); end
    launch_now(16'd16);
    run_cycles(-1);
    n_cmp++; if (rec_en[1] !== 1'b1 || rec_addr[1] !== '0) begin n_bad++; $display("FAIL b2b_addr0: got en=%b a=%0d want 1/0", rec_en[1], rec_addr[1]); end
    n_cmp++; if (rec_cnt[1] !== 2'd0 || rec_valid[1] !== 2'b00) begin n_bad++; $display("FAIL b2b_clear: got %0d/%b want 0/00", rec_cnt[1], rec_valid[1]); end
    n_cmp++; if (rec_done[N+2] !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", rec_done[N+2]); end
    n_cmp++; if (count !== 2'd1 || cand_valid !== 2'b01) begin n_bad++; $display("FAIL b2b_count: got %0d/%b want 1/01", count, cand_valid); end
    n_cmp++; if (cand_rho[15:0] !== 16'sd0 || cand_theta[7:0] !== 8'd1 || cand_votes !== {16'd0, 16'd20}) begin n_bad++; $display("FAIL b2b_slots: got rho=%h th=%h v=%h want 0/01/00000014", cand_rho, cand_theta, cand_votes); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_sorting();
    test_tie();
    test_start_while_busy();
    test_midscan_reset();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hough_line_select.md
# hough_line_select

Parametrised post-accumulation stage of the Hough pipeline. After `hough_top` signals done, it scans the full accumulator buffer through a 1-cycle-latency BRAM read port in rho-major/theta-minor order. It keeps the `NUM_CANDIDATES` highest-vote (rho, theta) cells at or above a runtime threshold and presents them sorted for downstream lane selection.

## Interface

- `RHO_RANGE`, default 2*RHOS from globals: number of rho bins.
- `THETAS`, default THETAS from globals: number of theta bins.
- `ACCUM_WIDTH`, default ACCUM_BUFF_WIDTH: vote width.
- `NUM_CANDIDATES`, default 4: kept lines, ≥1.
- `ADDR_WIDTH`, default $clog2(RHO_RANGE*THETAS): accumulator address width.

Ports:

- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a scan.
- `threshold` in ACCUM_WIDTH: minimum votes; sampled at start.
- `accum_rd_en` out 1: read enable.
- `accum_rd_addr` out ADDR_WIDTH: read address, equal to rho_idx*THETAS + theta.
- `accum_rd_data` in ACCUM_WIDTH: read data, valid one cycle after `accum_rd_en`.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle pulse when results are final.
- `cand_rho` out NUM_CANDIDATES×16 signed: rho = rho_idx − RHO_RANGE/2.
- `cand_theta` out NUM_CANDIDATES×8: theta index.
- `cand_votes` out NUM_CANDIDATES×ACCUM_WIDTH: vote count.
- `cand_valid` out NUM_CANDIDATES: slot holds a candidate.
- `count` out $clog2(NUM_CANDIDATES+1): number of valid slots.

## Operation

- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE/DONE + `start` → SCAN. On this transition: clear all slots, latch `threshold`, zero the rho/theta counters.
  - SCAN: assert `accum_rd_en` with the current address each cycle, advancing theta and then rho. After issuing the last address (RHO_RANGE*THETAS−1) → DRAIN.
  - DRAIN: one cycle consuming the final read data → DONE.
  - DONE: `done`=1 for exactly one cycle. Next cycle go to IDLE, or to SCAN if `start`=1.
- A one-cycle-delayed copy of rd_en/rho/theta tags the returning data. The sorter updates on every tagged data cycle.
- Qualification: votes ≥ latched threshold (equality accepted).
- Insertion: slots are sorted descending by votes. A new cell enters at the first position whose votes are strictly less than its own; lower slots shift down and the last slot drops out. On equal votes the earlier-scanned cell ranks higher, so ties never displace.
- `count` saturates at NUM_CANDIDATES.
- Results hold from DONE until the next accepted start.
- `start` in SCAN or DRAIN is ignored. `threshold` changes mid-scan have no effect.
- Reset at any time: FSM returns to IDLE, all outputs return to reset values, and the scan is abandoned. No read is issued in the cycle after reset deasserts.

## Timing

- Reset values: `accum_rd_en`=0, `accum_rd_addr`=0, `busy`=0, `done`=0, `cand_*`=0, `cand_valid`=0, `count`=0.
- With N = RHO_RANGE*THETAS and `start` sampled at edge 0:
  - `accum_rd_en`=1 in cycles 1..N, addresses 0..N−1 in order, no bubbles.
  - Data is consumed in cycles 2..N+1.
  - `done`=1 in cycle N+2.
  - `busy`=1 in cycles 1..N+1.
- Candidate outputs are registered. The final values are visible in the same cycle `done` is high.
- Back-to-back: `start` during DONE gives the next address 0 in the following cycle.

## Structure

- Shared package: RHO_RANGE, RHOS, THETAS, ACCUM_BUFF_WIDTH, and `line_cand_t` (rho, theta, votes, valid).
- Sub-module `hough_topn_sorter`: a registered NUM_CANDIDATES-deep insertion sorter.
  - Inputs: clear, in_valid, in_cand.
  - Outputs: the slot array and count.
  - Purely combinational compare, registered shift.
- The top module holds the FSM, counters, read-tag pipeline and threshold latch.

## Test plan

All scenarios use RHO_RANGE=4, THETAS=4, NUM_CANDIDATES=2, with a behavioural 1-cycle-latency BRAM model.

- **Reset:** assert `reset` asynchronously between edges → every output is 0 immediately; `accum_rd_en` stays 0 with no start.
- **All-zero buffer, threshold=1:** addresses 0..15 are issued in cycles 1..16, `done` is high in cycle 18, `count`=0, `cand_valid`=00.
- **Sorting:** addr5=10, addr9=20, addr14=15, threshold=5, all other cells 0 → slot0=(rho 0, theta 1, 20), slot1=(rho 1, theta 2, 15), `count`=2.
- **Tie and threshold edge:** addr3=12, addr7=12, addr10=11, threshold=12 → slot0=addr3 (rho −2, theta 3), slot1=addr7 (rho −1, theta 3), addr10 rejected.
- **Start while busy and mid-scan reset:** a second `start` at cycle 5 is ignored (address sequence unbroken, `done` at cycle 18). A separate run asserts `reset` at cycle 8: `busy`=0 and `accum_rd_en`=0 at once, no `done`.
- **Back-to-back:** `start` held during DONE → the new scan issues address 0 in the next cycle, candidates are cleared, and new results reflect a changed threshold.
